// File: rtl/axi_txn_sequencer.sv
// rtl/axi_txn_sequencer.sv - launches NUM_TXN INIT_AXI_TXN pulses, scores each TXN_DONE, reports run totals
// Optional watchdog in WAIT_DONE is built when SEQ_TIMEOUT_EN is defined.
module axi_txn_sequencer #(
  parameter int CNT_W          = 8,
  parameter int GAP_W          = 8,
  parameter int STOP_ON_ERR    = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             i_aclk,
  input  logic             i_areset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_num_txn,
  input  logic [GAP_W-1:0] i_gap_cycles,
  output logic             o_init_axi_txn,
  input  logic             i_txn_done,
  input  logic             i_axi_error,
  output logic             o_busy,
  output logic             o_run_done,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_fail_cnt,
  output logic             o_sticky_err,
  output logic             o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } state_t;

  state_t           r_state;
  logic             r_done_q;
  logic [CNT_W-1:0] r_rem;
  logic [GAP_W-1:0] r_gap_len;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_abort_pend;
  logic             r_init;
  logic             r_busy;
  logic             r_run_done;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_sticky_err;

  logic             w_done_rise;
  logic             w_err_stop;
  logic             w_last_txn;
  logic [CNT_W-1:0] w_pass_inc;
  logic [CNT_W-1:0] w_fail_inc;

  assign w_done_rise = i_txn_done & ~r_done_q;
  assign w_err_stop  = (STOP_ON_ERR != 0) & i_axi_error;
  assign w_last_txn  = (r_rem == CNT_W'(1));
  // Counters hold at all-ones rather than wrapping.
  assign w_pass_inc  = (&r_pass_cnt) ? r_pass_cnt : r_pass_cnt + CNT_W'(1);
  assign w_fail_inc  = (&r_fail_cnt) ? r_fail_cnt : r_fail_cnt + CNT_W'(1);

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state      <= S_IDLE;
      r_done_q     <= 1'b0;
      r_rem        <= '0;
      r_gap_len    <= '0;
      r_gap_cnt    <= '0;
      r_abort_pend <= 1'b0;
      r_init       <= 1'b0;
      r_busy       <= 1'b0;
      r_run_done   <= 1'b0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_sticky_err <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      r_wd_cnt     <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_done_q   <= i_txn_done;
      r_init     <= 1'b0;
      r_run_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rem        <= i_num_txn;
            r_gap_len    <= i_gap_cycles;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_sticky_err <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_timeout    <= 1'b0;
`endif
            r_busy       <= 1'b1;
            if (i_num_txn != '0) begin
              r_state <= S_LAUNCH;
              r_init  <= 1'b1;
            end else begin
              r_state <= S_FINISH;
            end
          end
        end

        S_LAUNCH: begin
          if (i_abort) begin
            r_state <= S_FINISH;
          end else begin
            r_state <= S_WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
            r_wd_cnt <= '0;
`endif
          end
        end

        S_WAIT_DONE: begin
          if (w_done_rise) begin
            if (i_axi_error) begin
              r_fail_cnt   <= w_fail_inc;
              r_sticky_err <= 1'b1;
            end else begin
              r_pass_cnt <= w_pass_inc;
            end
            r_rem <= r_rem - CNT_W'(1);
            // A same-cycle ABORT still lets this transaction be scored.
            if (w_last_txn || r_abort_pend || i_abort || w_err_stop) begin
              r_state <= S_FINISH;
            end else if (r_gap_len != '0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= r_gap_len - GAP_W'(1);
            end else begin
              r_state <= S_LAUNCH;
              r_init  <= 1'b1;
            end
          end else begin
            if (i_abort) begin
              r_abort_pend <= 1'b1;
            end
`ifdef SEQ_TIMEOUT_EN
            if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
              r_timeout    <= 1'b1;
              r_sticky_err <= 1'b1;
              r_fail_cnt   <= w_fail_inc;
              r_state      <= S_FINISH;
            end else begin
              r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
`endif
          end
        end

        S_GAP: begin
          if (i_abort) begin
            r_state <= S_FINISH;
          end else if (r_gap_cnt == '0) begin
            r_state <= S_LAUNCH;
            r_init  <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end

        S_FINISH: begin
          r_run_done   <= 1'b1;
          r_busy       <= 1'b0;
          r_abort_pend <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_init_axi_txn = r_init;
  assign o_busy         = r_busy;
  assign o_run_done     = r_run_done;
  assign o_pass_cnt     = r_pass_cnt;
  assign o_fail_cnt     = r_fail_cnt;
  assign o_sticky_err   = r_sticky_err;

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// tb/tb_axi_txn_sequencer.sv - scoreboard bench running STOP_ON_ERR=0 and STOP_ON_ERR=1 sequencers side by side
module tb_axi_txn_sequencer;

  typedef struct {
    int pass;
    int fail;
    int sticky;
    int tmo;
    int n_init;
    int spacing;
    int rd_lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       areset;
  logic       start;
  logic       abort;
  logic [7:0] num;
  logic [7:0] gap;

  logic [1:0] done_w = '0;
  logic [1:0] err_w  = '0;
  logic [1:0] init_w;
  logic [1:0] busy_w;
  logic [1:0] rd_w;
  logic [1:0] sticky_w;
  logic [1:0] tmo_w;
  logic [7:0] pass_w [2];
  logic [7:0] fail_w [2];

  int         rsp_lat   = 3;
  bit         rsp_stall = 1'b0;
  logic [7:0] err_mask  = '0;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_txn_sequencer #(
      .CNT_W(8),
      .GAP_W(8),
      .STOP_ON_ERR(g),
      .TIMEOUT_CYCLES(16)
    ) dut (
      .i_aclk(clk),
      .i_areset(areset),
      .i_start(start),
      .i_abort(abort),
      .i_num_txn(num),
      .i_gap_cycles(gap),
      .o_init_axi_txn(init_w[g]),
      .i_txn_done(done_w[g]),
      .i_axi_error(err_w[g]),
      .o_busy(busy_w[g]),
      .o_run_done(rd_w[g]),
      .o_pass_cnt(pass_w[g]),
      .o_fail_cnt(fail_w[g]),
      .o_sticky_err(sticky_w[g]),
      .o_timeout(tmo_w[g])
    );
  end

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Slave stand-in: answers each INIT with a one-cycle TXN_DONE after rsp_lat cycles.
  int   rsp_cnt [2];
  bit   rsp_pend[2];
  logic rsp_err [2];
  int   tix     [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (areset) begin
        rsp_pend[i] = 1'b0;
        done_w[i]   = 1'b0;
        err_w[i]    = 1'b0;
        tix[i]      = 0;
      end else begin
        if (!busy_w[i]) tix[i] = 0;
        if (done_w[i]) begin
          done_w[i] = 1'b0;
          err_w[i]  = 1'b0;
        end
        if (rsp_pend[i]) begin
          if (rsp_cnt[i] == 0) begin
            done_w[i]   = 1'b1;
            err_w[i]    = rsp_err[i];
            rsp_pend[i] = 1'b0;
          end else begin
            rsp_cnt[i]--;
          end
        end
        if (init_w[i] && !rsp_stall) begin
          rsp_pend[i] = 1'b1;
          rsp_cnt[i]  = rsp_lat - 1;
          rsp_err[i]  = err_mask[tix[i] % 8];
          tix[i]++;
        end
      end
    end
  end

  // Monitor: an input seen high here was sampled at this edge, so "event cycle" = cyc - 1.
  int         cyc = 0;
  int         trig_cyc[2];
  int         done_cyc[2];
  int         n_init  [2];
  logic [1:0] prev_done = '0;
  logic [1:0] prev_busy = '0;
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      bit   have;
      if (areset) begin
        n_init[i]    = 0;
        prev_done[i] = 1'b0;
        prev_busy[i] = 1'b0;
        if (i == 0) q0.delete();
        else        q1.delete();
      end else begin
        if ((start && !prev_busy[i]) || abort) trig_cyc[i] = cyc;
        if (done_w[i] && !prev_done[i]) done_cyc[i] = cyc;
        have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (have) e = (i == 0) ? q0[0] : q1[0];
        if (init_w[i]) begin
          if (!have)                 check("unexpected_init", i, 1, 0);
          else if (n_init[i] == 0)   check("start_to_init", i, cyc - trig_cyc[i] + 1, 1);
          else if (e.spacing >= 0)   check("init_spacing", i, cyc - done_cyc[i] + 1, e.spacing);
          n_init[i]++;
        end
        if (rd_w[i]) begin
          if (!have) begin
            check("unexpected_run_done", i, 1, 0);
          end else begin
            if (i == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            check("pass_cnt", i, int'(pass_w[i]), e.pass);
            check("fail_cnt", i, int'(fail_w[i]), e.fail);
            check("sticky_err", i, int'(sticky_w[i]), e.sticky);
            check("timeout", i, int'(tmo_w[i]), e.tmo);
            check("init_count", i, n_init[i], e.n_init);
            check("busy_at_run_done", i, int'(busy_w[i]), 0);
            if (e.rd_lat >= 0) check("run_done_latency", i, cyc - trig_cyc[i] + 1, e.rd_lat);
          end
          n_init[i] = 0;
        end
        prev_done[i] = done_w[i];
        prev_busy[i] = busy_w[i];
      end
    end
  end

  task automatic push2(input exp_t e0, input exp_t e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic run(input int n, input int g);
    num   = 8'(n);
    gap   = 8'(g);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    for (t = 0; t < 3000 && (q0.size() != 0 || q1.size() != 0); t++) @(negedge clk);
    check("runs_outstanding", 0, q0.size() + q1.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_init();
    int t;
    for (t = 0; t < 500 && !init_w[0]; t++) @(negedge clk);
    check("init_seen", 0, int'(init_w[0]), 1);
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_busy"}, i, int'(busy_w[i]), 0);
      check({tag, "_pass"}, i, int'(pass_w[i]), 0);
      check({tag, "_fail"}, i, int'(fail_w[i]), 0);
      check({tag, "_sticky"}, i, int'(sticky_w[i]), 0);
      check({tag, "_init"}, i, int'(init_w[i]), 0);
      check({tag, "_run_done"}, i, int'(rd_w[i]), 0);
      check({tag, "_timeout"}, i, int'(tmo_w[i]), 0);
    end
  endtask

  initial begin
    areset = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    num    = '0;
    gap    = '0;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    check_cleared("reset");

    // three clean back-to-back transactions
    rsp_lat = 3;
    push2('{3, 0, 0, 0, 3, 1, -1}, '{3, 0, 0, 0, 3, 1, -1});
    run(3, 0);
    wait_drain();

    // error on the second transaction, gap of 5; dut1 stops on it
    rsp_lat  = 2;
    err_mask = 8'b0000_0010;
    push2('{3, 1, 1, 0, 4, 6, -1}, '{1, 1, 1, 0, 2, 6, -1});
    run(4, 5);
    repeat (4) @(negedge clk);
    run(7, 0);
    wait_drain();
    err_mask = '0;

    // empty run
    push2('{0, 0, 0, 0, 0, -1, 2}, '{0, 0, 0, 0, 0, -1, 2});
    run(0, 0);
    wait_drain();

    // abort while in GAP
    rsp_lat = 2;
    push2('{1, 0, 0, 0, 1, -1, 2}, '{1, 0, 0, 0, 1, -1, 2});
    run(5, 10);
    wait_init();
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_drain();

    // abort while in WAIT_DONE: outstanding transaction still scored
    rsp_lat = 8;
    push2('{1, 0, 0, 0, 1, -1, -1}, '{1, 0, 0, 0, 1, -1, -1});
    run(5, 0);
    wait_init();
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_drain();

    // reset in WAIT_DONE after one scored transaction, then a normal run
    rsp_lat = 2;
    push2('{0, 0, 0, 0, 0, -1, -1}, '{0, 0, 0, 0, 0, -1, -1});
    run(3, 0);
    wait_init();
    @(negedge clk);
    wait_init();
    check("pre_reset_pass", 0, int'(pass_w[0]), 1);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    check_cleared("mid_run_reset");
    repeat (2) @(negedge clk);
    push2('{2, 0, 0, 0, 2, 2, -1}, '{2, 0, 0, 0, 2, 2, -1});
    run(2, 1);
    wait_drain();

    // stalled slave
    rsp_stall = 1'b1;
`ifdef SEQ_TIMEOUT_EN
    push2('{0, 1, 1, 1, 1, -1, -1}, '{0, 1, 1, 1, 1, -1, -1});
    run(1, 0);
    wait_drain();
`else
    push2('{0, 0, 0, 0, 0, -1, -1}, '{0, 0, 0, 0, 0, -1, -1});
    run(1, 0);
    repeat (60) @(negedge clk);
    check("stall_busy", 0, int'(busy_w[0]), 1);
    check("stall_busy", 1, int'(busy_w[1]), 1);
    check("stall_timeout", 0, int'(tmo_w[0]), 0);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
`endif
    rsp_stall = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
